// File: rtl/actmem_write_scheduler.sv
// actmem_write_scheduler: scatters compute-array output beats across the
// K*WEIGHT_STAGGER activation banks of one bank set. Bank and address
// counters wrap, pixels are counted for layer completion, and bad config or
// address overflow raise a sticky error.
//
// Optional feature macro: ACTMEM_WRITE_OUTREG_EN
//   defined   -> write outputs registered, writes appear 1 cycle after accept
//   undefined -> write outputs combinational, asserted in the accept cycle
//
// Ports:
//   clk_i, rst_i        clock, async active-high reset
//   latch_new_layer_i   load layer_no_i/num_pixels_i/bankset_i, start layer
//   wdata_i/valid_i     one pixel's words (word 0 first), valid/ready input
//   ready_o             beat accepted when valid_i && ready_o
//   stall_i             actmem write port blocked this cycle
//   wdata_o, write_enable_o, write_addr_o, write_bankset_o  per-bank writes
//   busy_o/done_o/error_o  RUN state, DONE state (level), sticky error
module actmem_write_scheduler #(
  parameter int N_O               = 128,
  parameter int N_I               = 128,
  parameter int WEIGHT_STAGGER    = 8,
  parameter int K                 = 3,
  parameter int IMAGEWIDTH        = 224,
  parameter int IMAGEHEIGHT       = 224,
  parameter int NUMACTMEMBANKSETS = 2,
  localparam int NUMBANKS      = K * WEIGHT_STAGGER,
  localparam int ETW           = N_I / WEIGHT_STAGGER,
  localparam int PBW           = ((ETW + 4) / 5) * 8,
  localparam int NUMWRITEBANKS = N_O / ETW,
  localparam int BSW           = (NUMACTMEMBANKSETS > 1) ? $clog2(NUMACTMEMBANKSETS) : 1,
  localparam int DEPTH         = (((IMAGEWIDTH * IMAGEHEIGHT * N_I) + NUMBANKS - 1) / NUMBANKS
                                  + ETW - 1) / ETW,
  localparam int AW            = $clog2(DEPTH),
  localparam int PW            = $clog2(IMAGEWIDTH * IMAGEHEIGHT + 1),
  localparam int LW            = $clog2(N_O) + 1,
  localparam int BW            = $clog2(NUMBANKS)
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                latch_new_layer_i,
  input  logic [LW-1:0]                       layer_no_i,
  input  logic [PW-1:0]                       num_pixels_i,
  input  logic [BSW-1:0]                      bankset_i,
  input  logic [0:NUMWRITEBANKS-1][PBW-1:0]   wdata_i,
  input  logic                                valid_i,
  output logic                                ready_o,
  input  logic                                stall_i,
  output logic [0:NUMBANKS-1][PBW-1:0]        wdata_o,
  output logic [0:NUMBANKS-1]                 write_enable_o,
  output logic [0:NUMBANKS-1][AW-1:0]         write_addr_o,
  output logic [BSW-1:0]                      write_bankset_o,
  output logic                                busy_o,
  output logic                                done_o,
  output logic                                error_o
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q, state_n;
  logic [BW-1:0]   b_q, b_n;
  logic [AW-1:0]   a_q, a_n;
  logic [PW-1:0]   pix_q;
  logic [PW-1:0]   np_q;
  logic [LW-1:0]   layer_no_q;
  logic [BSW-1:0]  bankset_q;
  logic            error_q;

  logic [LW:0]     wpp_q, wpp_in;
  logic            bad_cfg;
  logic            accept;
  logic            pix_last;

  logic [0:NUMBANKS-1][PBW-1:0] wdata_c;
  logic [0:NUMBANKS-1]          we_c;
  logic [0:NUMBANKS-1][AW-1:0]  wa_c;
  logic                         ovf_c;
  logic [BW:0]                  sum_c;
  logic [BW-1:0]                bank_c;
  logic [AW:0]                  addr_c;
  logic [BW:0]                  nsum;
  logic                         nwrap;

  // Words per pixel: ceil(layer_no / ETW), one bit wider than layer_no.
  assign wpp_q  = ({1'b0, layer_no_q} + (LW+1)'(ETW - 1)) / (LW+1)'(ETW);
  assign wpp_in = ({1'b0, layer_no_i} + (LW+1)'(ETW - 1)) / (LW+1)'(ETW);

  assign bad_cfg = (wpp_in == '0) || (wpp_in > (LW+1)'(NUMWRITEBANKS)) || (num_pixels_i == '0);

  assign ready_o  = (state_q == RUN) && !stall_i && !latch_new_layer_i;
  assign accept   = valid_i && ready_o;
  assign pix_last = (pix_q == np_q - PW'(1));

  // Scatter: word j lands on bank (b+j) mod NUMBANKS; wrapped words go to
  // the next address row. Overflowing addresses are dropped but flagged.
  always_comb begin
    wdata_c = '0;
    we_c    = '0;
    wa_c    = '0;
    ovf_c   = 1'b0;
    sum_c   = '0;
    bank_c  = '0;
    addr_c  = '0;
    if (accept) begin
      for (int j = 0; j < NUMWRITEBANKS; j++) begin
        if ((LW+1)'(j) < wpp_q) begin
          sum_c = (BW+1)'(b_q) + (BW+1)'(j);
          if (sum_c >= (BW+1)'(NUMBANKS)) begin
            bank_c = BW'(sum_c - (BW+1)'(NUMBANKS));
            addr_c = {1'b0, a_q} + (AW+1)'(1);
          end else begin
            bank_c = BW'(sum_c);
            addr_c = {1'b0, a_q};
          end
          if (addr_c > (AW+1)'(DEPTH - 1)) begin
            ovf_c = 1'b1;
          end else begin
            we_c[bank_c]    = 1'b1;
            wdata_c[bank_c] = wdata_i[j];
            wa_c[bank_c]    = AW'(addr_c);
          end
        end
      end
    end
  end

  // Counter advance for the next beat.
  always_comb begin
    nsum  = (BW+1)'(b_q) + (BW+1)'(wpp_q);
    nwrap = (nsum >= (BW+1)'(NUMBANKS));
    b_n   = nwrap ? BW'(nsum - (BW+1)'(NUMBANKS)) : BW'(nsum);
    a_n   = nwrap ? a_q + AW'(1) : a_q;
  end

  always_comb begin
    state_n = state_q;
    if (latch_new_layer_i) begin
      state_n = bad_cfg ? DONE : RUN;
    end else begin
      case (state_q)
        RUN:     if (accept && pix_last) state_n = DONE;
        default: state_n = state_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      b_q        <= '0;
      a_q        <= '0;
      pix_q      <= '0;
      np_q       <= '0;
      layer_no_q <= LW'(N_O);
      bankset_q  <= '0;
      error_q    <= 1'b0;
    end else begin
      state_q <= state_n;
      if (latch_new_layer_i) begin
        layer_no_q <= layer_no_i;
        np_q       <= num_pixels_i;
        bankset_q  <= bankset_i;
        b_q        <= '0;
        a_q        <= '0;
        pix_q      <= '0;
        error_q    <= bad_cfg;
      end else if (accept) begin
        b_q   <= b_n;
        a_q   <= a_n;
        pix_q <= pix_q + PW'(1);
        if (ovf_c) error_q <= 1'b1;
      end
    end
  end

`ifdef ACTMEM_WRITE_OUTREG_EN
  // Registered writes land together with the DONE transition of the last beat.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wdata_o         <= '0;
      write_enable_o  <= '0;
      write_addr_o    <= '0;
      write_bankset_o <= '0;
    end else begin
      wdata_o         <= wdata_c;
      write_enable_o  <= we_c;
      write_addr_o    <= wa_c;
      write_bankset_o <= bankset_q;
    end
  end
`else
  assign wdata_o         = wdata_c;
  assign write_enable_o  = we_c;
  assign write_addr_o    = wa_c;
  assign write_bankset_o = bankset_q;
`endif

  assign busy_o  = (state_q == RUN);
  assign done_o  = (state_q == DONE);
  assign error_o = error_q;

endmodule

// File: tb/tb_actmem_write_scheduler.sv
// Bench for actmem_write_scheduler. Image is 3x3 so DEPTH=3 and address
// overflow is reachable in a few beats; bank geometry stays 24/16/8.
module tb_actmem_write_scheduler;

  localparam int N_O = 128, N_I = 128, WS = 8, KK = 3, IW = 3, IH = 3, NBS = 2;
  localparam int NB    = KK * WS;
  localparam int ETW   = N_I / WS;
  localparam int PBW   = ((ETW + 4) / 5) * 8;
  localparam int NWB   = N_O / ETW;
  localparam int BSW   = (NBS > 1) ? $clog2(NBS) : 1;
  localparam int DEPTH = (((IW * IH * N_I) + NB - 1) / NB + ETW - 1) / ETW;
  localparam int AW    = $clog2(DEPTH);
  localparam int PW    = $clog2(IW * IH + 1);
  localparam int LW    = $clog2(N_O) + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic latch = 1'b0;
  logic valid = 1'b0;
  logic stall = 1'b0;
  logic [LW-1:0]  layer_no = '0;
  logic [PW-1:0]  num_pixels = '0;
  logic [BSW-1:0] bankset = '0;
  logic [0:NWB-1][PBW-1:0] wdata = '0;

  logic                   ready;
  logic [0:NB-1][PBW-1:0] wd;
  logic [0:NB-1]          we;
  logic [0:NB-1][AW-1:0]  wa;
  logic [BSW-1:0]         wbs;
  logic                   busy, done, error;

  int total = 0;
  int bad = 0;

  actmem_write_scheduler #(
    .N_O(N_O), .N_I(N_I), .WEIGHT_STAGGER(WS), .K(KK),
    .IMAGEWIDTH(IW), .IMAGEHEIGHT(IH), .NUMACTMEMBANKSETS(NBS)
  ) dut (
    .clk_i(clk), .rst_i(rst), .latch_new_layer_i(latch),
    .layer_no_i(layer_no), .num_pixels_i(num_pixels), .bankset_i(bankset),
    .wdata_i(wdata), .valid_i(valid), .ready_o(ready), .stall_i(stall),
    .wdata_o(wd), .write_enable_o(we), .write_addr_o(wa),
    .write_bankset_o(wbs), .busy_o(busy), .done_o(done), .error_o(error)
  );

  always #5 clk = ~clk;

  // Scoreboard: one expected write pattern per accepted beat.
  typedef struct {
    logic [0:NB-1]          we;
    logic [0:NB-1][AW-1:0]  wa;
    logic [0:NB-1][PBW-1:0] wd;
    logic [BSW-1:0]         bs;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int m_b = 0, m_a = 0, m_wpp = 0;
  logic [BSW-1:0] m_bs = '0;

  // Bank k receives word (k-b) mod NB when that offset is below wpp; banks
  // below b are the wrapped ones and use the next address row.
  task automatic model_step();
    exp_t e;
    int off, ad;
    if (latch) begin
      m_b = 0; m_a = 0; m_wpp = (int'(layer_no) + ETW - 1) / ETW; m_bs = bankset;
    end else if (valid && ready) begin
      e.we = '0; e.wa = '0; e.wd = '0; e.bs = m_bs;
      for (int k = 0; k < NB; k++) begin
        off = (k - m_b + NB) % NB;
        ad  = (k < m_b) ? m_a + 1 : m_a;
        if (off < m_wpp && ad <= DEPTH - 1) begin
          e.we[k] = 1'b1;
          e.wd[k] = wdata[off];
          e.wa[k] = AW'(ad);
        end
      end
      sb.push_back(e);
      m_a = m_a + (m_b + m_wpp) / NB;
      m_b = (m_b + m_wpp) % NB;
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
    end else begin
`ifndef ACTMEM_WRITE_OUTREG_EN
      model_step();
`endif
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        total += 4;
        if (we !== mon_e.we) begin bad++; $display("FAIL sb_enable act=%h req=%h", we, mon_e.we); end
        if (wa !== mon_e.wa) begin bad++; $display("FAIL sb_addr act=%h req=%h", wa, mon_e.wa); end
        if (wd !== mon_e.wd) begin bad++; $display("FAIL sb_data act=%h req=%h", wd, mon_e.wd); end
        if (wbs !== mon_e.bs) begin bad++; $display("FAIL sb_bankset act=%0d req=%0d", wbs, mon_e.bs); end
      end else begin
        total++;
        if (we !== '0) begin bad++; $display("FAIL spurious_write act=%h req=0", we); end
      end
`ifdef ACTMEM_WRITE_OUTREG_EN
      model_step();
`endif
    end
  end

  // Stimulus drivers (entered and left at posedge+1).
  task automatic do_latch(input int ln, input int np, input int bs);
    layer_no = LW'(ln); num_pixels = PW'(np); bankset = BSW'(bs); latch = 1'b1;
    @(posedge clk); #1;
    latch = 1'b0;
  endtask

  task automatic send_beats(input int n);
    int t;
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < NWB; j++) wdata[j] = $urandom;
      valid = 1'b1;
      t = 0;
      @(negedge clk);
      while (!ready && t < 20) begin @(negedge clk); t++; end
      total++;
      if (!ready) begin bad++; $display("FAIL beat_accept_timeout ready=%0b req=1", ready); end
      @(posedge clk); #1;
    end
    valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total += 6;
    if (busy !== 1'b0)  begin bad++; $display("FAIL reset_busy act=%0b req=0", busy); end
    if (done !== 1'b0)  begin bad++; $display("FAIL reset_done act=%0b req=0", done); end
    if (error !== 1'b0) begin bad++; $display("FAIL reset_error act=%0b req=0", error); end
    if (ready !== 1'b0) begin bad++; $display("FAIL reset_ready act=%0b req=0", ready); end
    if (we !== '0)      begin bad++; $display("FAIL reset_enable act=%h req=0", we); end
    if (wbs !== '0)     begin bad++; $display("FAIL reset_bankset act=%0d req=0", wbs); end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (ready !== 1'b0) begin bad++; $display("FAIL idle_ready act=%0b req=0", ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_full_layer();
    do_latch(128, 6, 0);
    @(negedge clk);
    total += 2;
    if (busy !== 1'b1)  begin bad++; $display("FAIL full_busy act=%0b req=1", busy); end
    if (ready !== 1'b1) begin bad++; $display("FAIL full_ready act=%0b req=1", ready); end
    @(posedge clk); #1;
    send_beats(5);
    @(negedge clk);
    total += 2;
    if (busy !== 1'b1) begin bad++; $display("FAIL full_busy_before_last act=%0b req=1", busy); end
    if (done !== 1'b0) begin bad++; $display("FAIL full_done_early act=%0b req=0", done); end
    @(posedge clk); #1;
    send_beats(1);
    @(negedge clk);
    total += 3;
    if (done !== 1'b1)  begin bad++; $display("FAIL full_done act=%0b req=1", done); end
    if (busy !== 1'b0)  begin bad++; $display("FAIL full_busy_after act=%0b req=0", busy); end
    if (error !== 1'b0) begin bad++; $display("FAIL full_error act=%0b req=0", error); end
    @(posedge clk); #1;
  endtask

  task automatic test_wrap();
    do_latch(80, 6, 0);
    send_beats(6);
    @(negedge clk);
    total += 2;
    if (done !== 1'b1)  begin bad++; $display("FAIL wrap_done act=%0b req=1", done); end
    if (error !== 1'b0) begin bad++; $display("FAIL wrap_error act=%0b req=0", error); end
    @(posedge clk); #1;
  endtask

  task automatic test_stall();
    do_latch(128, 4, 0);
    stall = 1'b1;
    for (int j = 0; j < NWB; j++) wdata[j] = $urandom;
    valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++;
      if (ready !== 1'b0) begin bad++; $display("FAIL stall_ready cycle=%0d act=%0b req=0", c, ready); end
    end
    @(posedge clk); #1;
    stall = 1'b0;
    @(negedge clk);
    total++;
    if (ready !== 1'b1) begin bad++; $display("FAIL stall_release_ready act=%0b req=1", ready); end
    @(posedge clk); #1;
    valid = 1'b0;
    @(negedge clk);
    total += 2;
    if (busy !== 1'b1) begin bad++; $display("FAIL stall_busy act=%0b req=1", busy); end
    if (done !== 1'b0) begin bad++; $display("FAIL stall_done act=%0b req=0", done); end
    @(posedge clk); #1;
    send_beats(3);
    @(negedge clk);
    total++;
    if (done !== 1'b1) begin bad++; $display("FAIL stall_layer_done act=%0b req=1", done); end
    @(posedge clk); #1;
  endtask

  task automatic test_relatch();
    do_latch(128, 6, 0);
    send_beats(2);
    for (int j = 0; j < NWB; j++) wdata[j] = $urandom;
    valid = 1'b1;
    layer_no = LW'(128); num_pixels = PW'(3); bankset = BSW'(1); latch = 1'b1;
    @(negedge clk);
    total++;
    if (ready !== 1'b0) begin bad++; $display("FAIL relatch_ready act=%0b req=0", ready); end
    @(posedge clk); #1;
    latch = 1'b0;
    @(negedge clk);
    total++;
    if (ready !== 1'b1) begin bad++; $display("FAIL relatch_run_ready act=%0b req=1", ready); end
    @(posedge clk); #1;
    valid = 1'b0;
    send_beats(2);
    @(negedge clk);
    total += 2;
    if (done !== 1'b1) begin bad++; $display("FAIL relatch_done act=%0b req=1", done); end
    if (wbs !== 1'b1)  begin bad++; $display("FAIL relatch_bankset act=%0d req=1", wbs); end
    @(posedge clk); #1;
  endtask

  task automatic test_errors();
    int cfg_ln[3] = '{0, 144, 128};
    int cfg_np[3] = '{5, 5, 0};
    for (int i = 0; i < 3; i++) begin
      do_latch(cfg_ln[i], cfg_np[i], 0);
      @(negedge clk);
      total += 3;
      if (done !== 1'b1)  begin bad++; $display("FAIL badcfg%0d_done act=%0b req=1", i, done); end
      if (error !== 1'b1) begin bad++; $display("FAIL badcfg%0d_error act=%0b req=1", i, error); end
      if (busy !== 1'b0)  begin bad++; $display("FAIL badcfg%0d_busy act=%0b req=0", i, busy); end
      @(posedge clk); #1;
    end
    do_latch(128, 10, 0);
    @(negedge clk);
    total += 2;
    if (error !== 1'b0) begin bad++; $display("FAIL ovf_error_cleared act=%0b req=0", error); end
    if (busy !== 1'b1)  begin bad++; $display("FAIL ovf_busy act=%0b req=1", busy); end
    @(posedge clk); #1;
    send_beats(9);
    @(negedge clk);
    total++;
    if (error !== 1'b0) begin bad++; $display("FAIL ovf_error_early act=%0b req=0", error); end
    @(posedge clk); #1;
    send_beats(1);
    @(negedge clk);
    total += 2;
    if (error !== 1'b1) begin bad++; $display("FAIL ovf_error act=%0b req=1", error); end
    if (done !== 1'b1)  begin bad++; $display("FAIL ovf_done act=%0b req=1", done); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    do_latch(80, 6, 1);
    send_beats(1);
    for (int j = 0; j < NWB; j++) wdata[j] = $urandom;
    valid = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    total += 8;
    if (busy !== 1'b0)  begin bad++; $display("FAIL midrst_busy act=%0b req=0", busy); end
    if (ready !== 1'b0) begin bad++; $display("FAIL midrst_ready act=%0b req=0", ready); end
    if (done !== 1'b0)  begin bad++; $display("FAIL midrst_done act=%0b req=0", done); end
    if (error !== 1'b0) begin bad++; $display("FAIL midrst_error act=%0b req=0", error); end
    if (we !== '0)      begin bad++; $display("FAIL midrst_enable act=%h req=0", we); end
    if (wa !== '0)      begin bad++; $display("FAIL midrst_addr act=%h req=0", wa); end
    if (wd !== '0)      begin bad++; $display("FAIL midrst_data_nonzero req=0"); end
    if (wbs !== '0)     begin bad++; $display("FAIL midrst_bankset act=%0d req=0", wbs); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    total += 2;
    if (busy !== 1'b0)  begin bad++; $display("FAIL postrst_busy act=%0b req=0", busy); end
    if (ready !== 1'b0) begin bad++; $display("FAIL postrst_ready act=%0b req=0", ready); end
    @(posedge clk); #1;
    valid = 1'b0;
    @(negedge clk);
    total++;
    if (sb.size() != 0) begin bad++; $display("FAIL sb_leftover act=%0d req=0", sb.size()); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_full_layer();
    test_wrap();
    test_stall();
    test_relatch();
    test_errors();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
